// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - multi-cycle data-memory responder for the MEM-stage memory port
// Optional DMEM_RANGE_CHECK_EN: flag addresses beyond the RAM with err instead of aliasing.
module dmem_resp #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [31:0] l_addr;
    logic [3:0]  l_sel;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH];

    // With WAIT=0 the response is taken on the accepting edge, so the
    // request fields come straight from the inputs instead of the latches.
    logic              from_in;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [3:0]        c_sel;
    logic [31:0]       c_wdata;
    logic [ADDR_W-1:0] idx;
    logic              oor;
    logic              go_resp;

    assign from_in = (state == IDLE);
    assign c_we    = from_in ? we    : l_we;
    assign c_addr  = from_in ? addr  : l_addr;
    assign c_sel   = from_in ? sel   : l_sel;
    assign c_wdata = from_in ? wdata : l_wdata;
    assign idx     = c_addr[ADDR_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    assign oor = |c_addr[31:ADDR_W+2];
    logic unused_addr;
    assign unused_addr = ^c_addr[1:0];
`else
    assign oor = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{c_addr[1:0], c_addr[31:ADDR_W+2]};
`endif

    // Gated by rst so an idle-state store during reset never commits.
    assign go_resp = rst && (((state == IDLE) && req && (WAIT == 0)) ||
                             ((state == WAITING) && (cnt == 4'd1)));

    always_ff @(posedge clk) begin
        if (go_resp && c_we && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (c_sel[i]) begin
                    mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            l_we    <= 1'b0;
            l_addr  <= 32'd0;
            l_sel   <= 4'd0;
            l_wdata <= 32'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        l_we    <= we;
                        l_addr  <= addr;
                        l_sel   <= sel;
                        l_wdata <= wdata;
                        busy    <= 1'b1;
                        if (WAIT == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAITING;
                            cnt   <= 4'(WAIT);
                        end
                    end
                end
                WAITING: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (go_resp) begin
                ack <= 1'b1;
                err <= oor;
                if (!c_we) begin
                    rdata <= oor ? 32'd0 : mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - scoreboard bench for dmem_resp with WAIT=2 and WAIT=0 instances
module tb_dmem_resp;

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req2, we2, ack2, err2, busy2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [3:0]  sel2;
    logic        req0, we0, ack0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  sel0;

    dmem_resp #(.ADDR_W(10), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .sel(sel2),
        .wdata(wdata2), .ack(ack2), .rdata(rdata2), .err(err2), .busy(busy2)
    );

    dmem_resp #(.ADDR_W(10), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .sel(sel0),
        .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    typedef struct {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ack2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("w2 spurious ack", 32'(ack2), 32'd0);
            end else begin
                e = q2.pop_front();
                chk("w2 rdata", rdata2, e.rd);
                chk("w2 err", 32'(err2), 32'(e.er));
            end
        end
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("w0 spurious ack", 32'(ack0), 32'd0);
            end else begin
                e = q0.pop_front();
                chk("w0 rdata", rdata0, e.rd);
                chk("w0 err", 32'(err0), 32'(e.er));
            end
        end
    end

    task automatic op2(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] erd, input logic eer);
        int k;
        k = 0;
        q2.push_back('{rd: erd, er: eer});
        @(negedge clk);
        req2 = 1'b1; we2 = w; addr2 = a; sel2 = s; wdata2 = d;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == 1) chk("w2 busy after accept", 32'(busy2), 32'd1);
        end while (ack2 !== 1'b1 && k < 20);
        req2 = 1'b0;
        chk("w2 ack latency", 32'(k), 32'd3);
        @(posedge clk); #1;
        chk("w2 busy after ack", 32'(busy2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h10; sel2 = 4'hF; wdata2 = 32'h55555555;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; sel0 = 4'hF; wdata0 = 32'h66666666;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ack", 32'(ack2), 32'd0);
        chk("reset err", 32'(err2), 32'd0);
        chk("reset busy", 32'(busy2), 32'd0);
        chk("reset rdata", rdata2, 32'd0);
        chk("reset w0 ack", 32'(ack0), 32'd0);
        chk("reset w0 busy", 32'(busy0), 32'd0);
        req2 = 1'b0; req0 = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle no ack", 32'(ack2), 32'd0);
        chk("idle no busy", 32'(busy2), 32'd0);

        op2(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0);
        op2(1'b0, 32'h10, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0);
        op2(1'b1, 32'h10, 4'h2, 32'h0000AA00, 32'hDEADBEEF, 1'b0);
        op2(1'b0, 32'h10, 4'hF, 32'h0,        32'hDEADAAEF, 1'b0);
        op2(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'hDEADAAEF, 1'b0);
        op2(1'b0, 32'h10, 4'h0, 32'h0,        32'hDEADAAEF, 1'b0);

        op2(1'b1, 32'h0,    4'hF, 32'h0BADC0DE, 32'hDEADAAEF, 1'b0);
        op2(1'b1, 32'h1000, 4'hF, 32'h12345678, 32'hDEADAAEF, RC);
        op2(1'b0, 32'h0,    4'hF, 32'h0, RC ? 32'h0BADC0DE : 32'h12345678, 1'b0);
        op2(1'b0, 32'h1000, 4'hF, 32'h0, RC ? 32'h0 : 32'h12345678, RC);

        op2(1'b1, 32'h30, 4'hF, 32'h11112222, RC ? 32'h0 : 32'h12345678, 1'b0);
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h30; sel2 = 4'hF; wdata2 = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("midwait busy", 32'(busy2), 32'd1);
        @(negedge clk);
        rst = 1'b0; req2 = 1'b0;
        #1;
        chk("midwait reset ack", 32'(ack2), 32'd0);
        chk("midwait reset busy", 32'(busy2), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        op2(1'b0, 32'h30, 4'hF, 32'h0, 32'h11112222, 1'b0);

        @(negedge clk);
        req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = 0;
            q0.push_back('{rd: (i == 0) ? 32'h0 : ((i < 3) ? 32'hA5A50001 : 32'h5A5A0002), er: 1'b0});
            we0 = (i % 2 == 0);
            addr0 = 32'h20;
            sel0 = 4'hF;
            wdata0 = (i < 2) ? 32'hA5A50001 : 32'h5A5A0002;
            do begin
                @(posedge clk); #1;
                k++;
            end while (ack0 !== 1'b1 && k < 20);
            chk("w0 ack spacing", 32'(k), (i == 0) ? 32'd1 : 32'd2);
        end
        req0 = 1'b0;

        repeat (5) @(negedge clk);
        chk("w2 queue drained", 32'(q2.size()), 32'd0);
        chk("w0 queue drained", 32'(q0.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
